// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word requests for the current PC over a
// req/gnt/rvalid handshake and buffers tagged instructions for decode.
module instr_fetch #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifq_valid,
  output logic [31:0] ifq_instr,
  output logic [31:0] ifq_pc,
  input  logic        ifq_ready
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = CW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          drop_q, drop_d;
  logic          valid_q, valid_d;
  logic [31:0]   req_pc_q, req_pc_d;
  ifq_entry_t    mem_q [QDEPTH];

  logic          push_c;
  logic          pop_c;
  logic          space_c;
  logic          grant_c;
  logic [FW-1:0] need_c;
  logic [FW-1:0] cap_c;

  // Request/handshake decode; a slot must remain after this cycle's push/pop.
  always_comb begin
    push_c     = imem_rvalid && (state_q == WAIT) && !drop_q && !flush;
    pop_c      = valid_q && ifq_ready;
    need_c     = FW'(count_q) + FW'(push_c);
    cap_c      = FW'(QDEPTH) + FW'(pop_c);
    space_c    = need_c < cap_c;
    imem_req   = reset && !flush && space_c && ((state_q == IDLE) || imem_rvalid);
    grant_c    = imem_req && imem_gnt;
    pc_advance = grant_c;
    imem_addr  = {pc[31:2], 2'b00};
  end

  // Next-state logic for the FSM, queue pointers and stale-response tracking.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    drop_d   = drop_q;
    req_pc_d = req_pc_q;

    unique case (state_q)
      IDLE:    if (grant_c) state_d = WAIT;
      WAIT:    if (imem_rvalid && !grant_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_c) req_pc_d = pc;

    // A response consumed while dropping is the stale one.
    if (imem_rvalid && (state_q == WAIT)) drop_d = 1'b0;

    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      if ((state_q == WAIT) && !imem_rvalid) drop_d = 1'b1;
    end else begin
      if (push_c) tail_d = tail_q + PW'(1);
      if (pop_c)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      req_pc_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      req_pc_q <= req_pc_d;
      if (push_c) mem_q[tail_q] <= '{pc: req_pc_q, instr: imem_rdata};
    end
  end

  assign ifq_valid = valid_q;
  assign ifq_instr = mem_q[head_q].instr;
  assign ifq_pc    = mem_q[head_q].pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reactive memory model feeding a scoreboard of
// expected {pc, instr} pairs, plus directed checks on the handshake.
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifq_valid;
  logic [31:0] ifq_instr;
  logic [31:0] ifq_pc;
  logic        ifq_ready;

  instr_fetch #(.QDEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifq_valid   (ifq_valid),
    .ifq_instr   (ifq_instr),
    .ifq_pc      (ifq_pc),
    .ifq_ready   (ifq_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic        outstanding = 1'b0;
  logic        discard     = 1'b0;
  logic        rsp_block   = 1'b0;
  logic        auto_pc     = 1'b0;
  logic [31:0] rsp_pc      = '0;
  int          cyc         = 0;
  int          pops        = 0;
  int          first_pop   = 0;
  int          last_pop    = 0;

  function automatic logic [31:0] mk(input logic [31:0] p);
    return 32'h2008_0005 ^ {p[23:0], 8'h00};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: score this cycle's outputs, then advance the memory and PC models.
  task automatic tick();
    logic [63:0] e;
    logic        adv;
    #1;
    if (ifq_valid && ifq_ready) begin
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(ifq_pc), 64'hffff_ffff_ffff_ffff);
      end else begin
        e = sb.pop_front();
        check_eq("ifq_head", {ifq_pc, ifq_instr}, e);
      end
    end
    if (flush) sb.delete();
    if (imem_rvalid) begin
      if (!discard && !flush) sb.push_back({rsp_pc, mk(rsp_pc)});
      discard     = 1'b0;
      outstanding = 1'b0;
    end else if (flush && outstanding) begin
      discard = 1'b1;
    end
    adv = imem_req && imem_gnt;
    if (adv) begin
      outstanding = 1'b1;
      rsp_pc      = pc;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    imem_rvalid = outstanding && !rsp_block;
    imem_rdata  = imem_rvalid ? mk(rsp_pc) : 32'h0;
    if (adv && auto_pc) pc = pc + 32'd4;
  endtask

  task automatic drain(input int n);
    ifq_ready = 1'b1;
    imem_gnt  = 1'b0;
    repeat (n) tick();
    check_eq("drain_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("drain_valid", 64'(ifq_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    pc          = 32'h47;
    flush       = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    ifq_ready   = 1'b0;

    // Reset state
    #2;
    check_eq("rst_req", 64'(imem_req), 64'd0);
    check_eq("rst_adv", 64'(pc_advance), 64'd0);
    check_eq("rst_valid", 64'(ifq_valid), 64'd0);
    check_eq("rst_instr", 64'(ifq_instr), 64'd0);
    check_eq("rst_pc", 64'(ifq_pc), 64'd0);
    check_eq("rst_addr", 64'(imem_addr), 64'h44);
    pc = 32'h0;
    @(negedge clock);
    @(negedge clock);

    // Reset release and first fetch
    reset = 1'b1;
    #1;
    check_eq("first_req", 64'(imem_req), 64'd1);
    check_eq("first_adv", 64'(pc_advance), 64'd1);
    tick();
    imem_gnt = 1'b0;
    pc       = 32'h40;
    #1;
    check_eq("first_nobypass", 64'(ifq_valid), 64'd0);
    check_eq("stall_req0", 64'(imem_req), 64'd1);
    check_eq("stall_addr0", 64'(imem_addr), 64'h40);
    check_eq("stall_adv0", 64'(pc_advance), 64'd0);
    tick();
    #1;
    check_eq("first_valid", 64'(ifq_valid), 64'd1);
    check_eq("first_instr", 64'(ifq_instr), 64'h2008_0005);
    check_eq("first_pc", 64'(ifq_pc), 64'h0);

    // Stalled grant: request and address held until granted
    for (int i = 1; i < 3; i++) begin
      if (i > 1) #1;
      check_eq("stall_req", 64'(imem_req), 64'd1);
      check_eq("stall_addr", 64'(imem_addr), 64'h40);
      check_eq("stall_adv", 64'(pc_advance), 64'd0);
      tick();
    end
    imem_gnt = 1'b1;
    #1;
    check_eq("stall_grant_adv", 64'(pc_advance), 64'd1);
    tick();
    imem_gnt = 1'b0;
    #1;
    check_eq("full_req_drop", 64'(imem_req), 64'd0);
    tick();
    #1;
    check_eq("full_req_hold", 64'(imem_req), 64'd0);
    drain(4);

    // Queue full backpressure, PC stepping 0x0/0x4/0x8
    ifq_ready = 1'b0;
    auto_pc   = 1'b1;
    pc        = 32'h0;
    imem_gnt  = 1'b1;
    tick();
    tick();
    #1;
    check_eq("bp_req_last_slot", 64'(imem_req), 64'd0);
    check_eq("bp_pc_held", 64'(pc), 64'h8);
    tick();
    #1;
    check_eq("bp_full_req", 64'(imem_req), 64'd0);
    check_eq("bp_full_adv", 64'(pc_advance), 64'd0);
    check_eq("bp_head_pc", 64'(ifq_pc), 64'h0);
    tick();
    ifq_ready = 1'b1;
    #1;
    check_eq("bp_pop_req", 64'(imem_req), 64'd1);
    check_eq("bp_pop_adv", 64'(pc_advance), 64'd1);
    check_eq("bp_pop_addr", 64'(imem_addr), 64'h8);
    tick();
    drain(4);

    // Flush with a response in flight
    ifq_ready = 1'b0;
    auto_pc   = 1'b0;
    pc        = 32'h8;
    imem_gnt  = 1'b1;
    tick();
    pc        = 32'h10;
    rsp_block = 1'b1;
    #1;
    check_eq("fl_grant10", 64'(pc_advance), 64'd1);
    tick();
    pc        = 32'h100;
    imem_gnt  = 1'b0;
    flush     = 1'b1;
    rsp_block = 1'b0;
    #1;
    check_eq("fl_pre_valid", 64'(ifq_valid), 64'd1);
    check_eq("fl_req_off", 64'(imem_req), 64'd0);
    tick();
    flush    = 1'b0;
    imem_gnt = 1'b1;
    #1;
    check_eq("fl_emptied", 64'(ifq_valid), 64'd0);
    check_eq("fl_refetch_adv", 64'(pc_advance), 64'd1);
    tick();
    imem_gnt = 1'b0;
    #1;
    check_eq("fl_stale_dropped", 64'(ifq_valid), 64'd0);
    tick();
    #1;
    check_eq("fl_new_valid", 64'(ifq_valid), 64'd1);
    check_eq("fl_new_pc", 64'(ifq_pc), 64'h100);
    check_eq("fl_new_instr", 64'(ifq_instr), 64'(mk(32'h100)));
    drain(3);

    // Streaming: 1-cycle memory, decode always ready
    pops      = 0;
    ifq_ready = 1'b1;
    auto_pc   = 1'b1;
    pc        = 32'h0;
    for (int i = 0; i < 40 && pops < 8; i++) begin
      imem_gnt = (pc < 32'h20);
      tick();
    end
    check_eq("stream_count", 64'(pops), 64'd8);
    check_eq("stream_gapless", 64'(last_pop - first_pop), 64'd7);
    drain(3);

    // Async reset while WAIT with one entry queued
    ifq_ready = 1'b0;
    pc        = 32'h200;
    imem_gnt  = 1'b1;
    tick();
    rsp_block = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #1;
    check_eq("ar_pre_valid", 64'(ifq_valid), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("ar_valid", 64'(ifq_valid), 64'd0);
    check_eq("ar_req", 64'(imem_req), 64'd0);
    check_eq("ar_pc", 64'(ifq_pc), 64'd0);
    sb.delete();
    outstanding = 1'b0;
    discard     = 1'b0;
    rsp_block   = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("ar_release_req", 64'(imem_req), 64'd1);
    check_eq("ar_release_valid", 64'(ifq_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage located directly downstream of the program counter register. It takes the current PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned instructions, each tagged with its PC, are buffered in a small queue and handed to decode over a valid/ready handshake. It also produces `pc_advance`, which gates the PC's next-address mux so the PC only moves once the current address has been accepted by memory.

## Interface

- `QDEPTH`, default 2: fetch queue entries; must be a power of two and ≥ 2.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset.
- `pc`  in  32  current PC (program counter register output).
- `flush`  in  1  discard queue and in-flight fetch (branch/jump redirect).
- `pc_advance`  out  1  PC may load its next value this edge.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  request address, always `{pc[31:2],2'b00}`.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `ifq_valid`  out  1  queue head is valid.
- `ifq_instr`  out  32  queue-head instruction.
- `ifq_pc`  out  32  PC of the queue-head instruction.
- `ifq_ready`  in  1  decode consumes the head this cycle.

## Operation

- FSM has two states:
  - `IDLE`: no request outstanding.
  - `WAIT`: granted request whose response has not yet arrived.
- Transitions:
  - `IDLE` → `WAIT` on `imem_req & imem_gnt`.
  - `WAIT` → `IDLE` on `imem_rvalid` unless a new request is granted the same cycle; in that case stay in `WAIT`.
- Queue accounting:
  - `push` = `imem_rvalid & state==WAIT & !drop & !flush`.
  - `pop` = `ifq_valid & ifq_ready`.
  - `free` = `QDEPTH - count + pop - push`.
- `imem_req` = `!flush & free≥1 & (state==IDLE | (state==WAIT & imem_rvalid))`. At most one request is outstanding.
- `imem_req` must hold, with `imem_addr` stable, until `imem_gnt`. Exceptions: `flush` drops `imem_req` that cycle; `free` dropping to 0 cannot occur while a request is pending.
- `pc_advance` = `imem_req & imem_gnt`.
- On grant, `req_pc` captures `pc`. On `push`, `{req_pc, imem_rdata}` is written at the tail.
- `count` is a clog2(`QDEPTH`)+1-bit counter; head and tail pointers wrap modulo `QDEPTH`.
- `ifq_valid` = `count≠0`. `ifq_instr`/`ifq_pc` come from head-entry storage and are not bypassed.
- Flush:
  - Next edge: `count`←0 and pointers←0.
  - If state is `WAIT` and `imem_rvalid` is not present that cycle, set `drop`.
  - While `drop`=1, the next `imem_rvalid` is discarded and clears `drop`.
  - The state still follows its normal transitions.
- `imem_rvalid` in `IDLE` is a protocol error and is ignored.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full queue: no request is issued, so overflow is impossible.
- Empty queue with `ifq_ready`=1: no pop, no change.

## Timing

- Reset, asynchronous while `reset`=0, sets:
  - state `IDLE`, `count` 0, pointers 0, `drop` 0, `req_pc` 0, storage 0.
  - `imem_req`=0 while `reset`=0.
  - `ifq_valid`=0, `pc_advance`=0, `ifq_instr`=0, `ifq_pc`=0.
  - `imem_addr` follows `pc`.
- Reset asserted mid-fetch loses the outstanding response; the memory side is reset together with this block.
- First cycle after reset release with an empty queue: `imem_req`=1.
- Grant-to-data: `imem_rvalid` may arrive no earlier than the cycle after grant. If `rvalid` is seen in cycle N, `ifq_valid`=1 from cycle N+1.
- With a 1-cycle memory, grant every cycle, and decode always ready: throughput is 1 instruction/cycle in steady state (the back-to-back request in `WAIT`).
- `imem_req` has a combinational path from `ifq_ready`, `imem_rvalid` and `flush`. `pc_advance` has a combinational path from `imem_gnt`. All other outputs are registered.

## Test plan

- **Reset and first fetch:** `reset`=0 then 1, `pc`=0x0, `imem_gnt`=1, `rvalid` one cycle later with `rdata`=0x20080005. Expect `pc_advance` pulse in cycle 1; `ifq_valid`=1, `ifq_instr`=0x20080005, `ifq_pc`=0x0 in cycle 3.
- **Stalled grant:** `pc`=0x40, `imem_gnt`=0 for 3 cycles. Expect `imem_req`=1 and `imem_addr`=0x40 held steady, `pc_advance`=0 in those cycles, and a pulse on the 4th cycle when `gnt`=1.
- **Queue full backpressure:** `ifq_ready`=0, PC stepping 0x0/0x4/0x8. Expect `count` to reach 2 and `imem_req`=0 with 0x8 not requested. Raising `ifq_ready` pops 0x0 and the request for 0x8 issues the same cycle.
- **Flush with response in flight:** grant 0x10, then `flush`=1 before `rvalid`. Expect the queue to empty next edge, the 0x10 response to be dropped (`ifq_valid` stays 0), and the next fetch at the new `pc`=0x100 to be queued normally.
- **Streaming:** 1-cycle memory, `ifq_ready`=1, 8 sequential PCs 0x0–0x1C. Expect 8 instructions in order with matching `ifq_pc`, no gaps after the first, and pointer wrap exercised.
- **Async reset mid-operation:** `reset`=0 asserted in `WAIT` with 1 entry queued. Expect `ifq_valid`=0 and `imem_req`=0 immediately, not waiting for a clock edge.
